// File: rtl/fetch_if.sv
// Fetch-stage bus bundle: writeback PC load, instruction-memory read port,
// decode hand-off and sticky status flags.
interface fetch_if;
  localparam int unsigned XLEN = 32;

  logic [XLEN-1:0] pc_wd_i;
  logic            pc_valid_i;
  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_ack_i;
  logic [XLEN-1:0] imem_data_i;
  logic [XLEN-1:0] ir_o;
  logic [XLEN-1:0] pc_o;
  logic            ir_valid_o;
  logic            ir_ready_i;
  logic            overrun_o;
  logic            misalign_o;

  // Fetch unit side
  modport master (
    input  pc_wd_i, pc_valid_i, imem_ack_i, imem_data_i, ir_ready_i,
    output imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o, overrun_o, misalign_o
  );

  // Environment side (writeback, instruction memory, decode)
  modport slave (
    output pc_wd_i, pc_valid_i, imem_ack_i, imem_data_i, ir_ready_i,
    input  imem_req_o, imem_addr_o, ir_o, pc_o, ir_valid_o, overrun_o, misalign_o
  );
endinterface

// File: rtl/fetch.sv
// Instruction fetch FSM: issues one imem read per PC, holds the fetched word
// for decode, then waits for the next PC from writeback.
// Optional macro FETCH_MISALIGN_EN: a misaligned PC load enters a sticky FAULT
// state instead of being silently aligned.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic   clk,
  input  logic   reset,
  fetch_if.master bus
);
  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    REQ     = 3'd1,
    HOLD    = 3'd2,
    WAIT_PC = 3'd3,
    FAULT   = 3'd4
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] ir;
  logic            req;
  logic            valid;
  logic            overrun;
  logic            misalign;

  // Sequencing, PC/IR capture and sticky flags; all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      ir       <= '0;
      req      <= 1'b0;
      valid    <= 1'b0;
      overrun  <= 1'b0;
      misalign <= 1'b0;
    end else begin
      if (bus.pc_valid_i && (state != WAIT_PC)) overrun <= 1'b1;
      case (state)
        BOOT: begin
          req   <= 1'b1;
          state <= REQ;
        end
        REQ: begin
          if (bus.imem_ack_i) begin
            ir    <= bus.imem_data_i;
            req   <= 1'b0;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.ir_ready_i) begin
            valid <= 1'b0;
            state <= WAIT_PC;
          end
        end
        WAIT_PC: begin
          if (bus.pc_valid_i) begin
`ifdef FETCH_MISALIGN_EN
            pc <= bus.pc_wd_i;
            if (bus.pc_wd_i[1:0] != 2'b00) begin
              misalign <= 1'b1;
              state    <= FAULT;
            end else begin
              req   <= 1'b1;
              state <= REQ;
            end
`else
            pc    <= bus.pc_wd_i & ALIGN_MASK;
            req   <= 1'b1;
            state <= REQ;
`endif
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          req   <= 1'b0;
          valid <= 1'b0;
          state <= BOOT;
        end
      endcase
    end
  end

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc;
  assign bus.ir_o        = ir;
  assign bus.pc_o        = pc;
  assign bus.ir_valid_o  = valid;
  assign bus.overrun_o   = overrun;
`ifdef FETCH_MISALIGN_EN
  assign bus.misalign_o  = misalign;
`else
  assign bus.misalign_o  = 1'b0;
`endif
endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch unit; expected values are hand-computed.
module tb_fetch;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  fetch_if f ();

  fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    f.pc_wd_i = '0;
    f.pc_valid_i = 1'b0;
    f.imem_ack_i = 1'b0;
    f.imem_data_i = '0;
    f.ir_ready_i = 1'b0;
    tick();
    tick();
    // Reset values
    chk("rst_req", 32'(f.imem_req_o), 32'd0);
    chk("rst_valid", 32'(f.ir_valid_o), 32'd0);
    chk("rst_ir", f.ir_o, 32'h0);
    chk("rst_pc", f.pc_o, 32'h0);
    chk("rst_overrun", 32'(f.overrun_o), 32'd0);
    chk("rst_misalign", 32'(f.misalign_o), 32'd0);

    // Release reset away from the edge; BOOT -> REQ on the first edge
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("boot_req", 32'(f.imem_req_o), 32'd1);
    chk("boot_addr", f.imem_addr_o, 32'h0);
    tick();
    chk("req_wait_req", 32'(f.imem_req_o), 32'd1);
    chk("req_wait_addr", f.imem_addr_o, 32'h0);
    // Ack after two request cycles
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'h0000_0093;
    tick();
    f.imem_ack_i = 1'b0;
    f.imem_data_i = '0;
    chk("hold_valid", 32'(f.ir_valid_o), 32'd1);
    chk("hold_req", 32'(f.imem_req_o), 32'd0);
    chk("hold_ir", f.ir_o, 32'h0000_0093);
    chk("hold_pc", f.pc_o, 32'h0);

    // Decode stalls for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_ir", f.ir_o, 32'h0000_0093);
      chk("stall_valid", 32'(f.ir_valid_o), 32'd1);
    end
    f.ir_ready_i = 1'b1;
    tick();
    f.ir_ready_i = 1'b0;
    chk("accept_valid", 32'(f.ir_valid_o), 32'd0);
    chk("accept_ir", f.ir_o, 32'h0000_0093);

    // Ack in WAIT_PC is ignored
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'hDEAD_BEEF;
    tick();
    f.imem_ack_i = 1'b0;
    chk("waitpc_ack_req", 32'(f.imem_req_o), 32'd0);
    chk("waitpc_ack_ir", f.ir_o, 32'h0000_0093);
    chk("waitpc_ack_valid", 32'(f.ir_valid_o), 32'd0);

    // New PC, ack in the first REQ cycle
    f.pc_valid_i = 1'b1;
    f.pc_wd_i = 32'h0000_0104;
    tick();
    f.pc_valid_i = 1'b0;
    chk("pc104_req", 32'(f.imem_req_o), 32'd1);
    chk("pc104_addr", f.imem_addr_o, 32'h0000_0104);
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'h0000_0011;
    tick();
    f.imem_ack_i = 1'b0;
    chk("pc104_req_drop", 32'(f.imem_req_o), 32'd0);
    chk("pc104_valid", 32'(f.ir_valid_o), 32'd1);
    chk("pc104_ir", f.ir_o, 32'h0000_0011);
    chk("pc104_pc", f.pc_o, 32'h0000_0104);
    chk("pc104_overrun", 32'(f.overrun_o), 32'd0);
    f.ir_ready_i = 1'b1;
    tick();
    f.ir_ready_i = 1'b0;

    // PC pulse during REQ is discarded and flags overrun
    f.pc_valid_i = 1'b1;
    f.pc_wd_i = 32'h0000_0200;
    tick();
    f.pc_wd_i = 32'h0000_0300;
    tick();
    f.pc_valid_i = 1'b0;
    chk("ovr_addr", f.imem_addr_o, 32'h0000_0200);
    chk("ovr_req", 32'(f.imem_req_o), 32'd1);
    chk("ovr_flag", 32'(f.overrun_o), 32'd1);
    tick();
    chk("ovr_sticky", 32'(f.overrun_o), 32'd1);
    chk("ovr_addr2", f.imem_addr_o, 32'h0000_0200);

    // Reset mid-request drops the request immediately
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(f.imem_req_o), 32'd0);
    chk("midrst_overrun", 32'(f.overrun_o), 32'd0);
    chk("midrst_pc", f.pc_o, 32'h0);
    tick();
    // Stale ack present while in BOOT
    @(negedge clk);
    rst_n = 1'b1;
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'h0000_0BAD;
    tick();
    f.imem_ack_i = 1'b0;
    f.imem_data_i = '0;
    chk("stale_req", 32'(f.imem_req_o), 32'd1);
    chk("stale_valid", 32'(f.ir_valid_o), 32'd0);
    chk("stale_ir", f.ir_o, 32'h0);
    chk("stale_addr", f.imem_addr_o, 32'h0);
    tick();
    chk("stale_req2", 32'(f.imem_req_o), 32'd1);
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'h0000_0055;
    tick();
    f.imem_ack_i = 1'b0;
    chk("refetch_ir", f.ir_o, 32'h0000_0055);
    chk("refetch_pc", f.pc_o, 32'h0);
    chk("refetch_valid", 32'(f.ir_valid_o), 32'd1);
    f.ir_ready_i = 1'b1;
    tick();
    f.ir_ready_i = 1'b0;

    // Top-of-address-space PC fetched as-is
    f.pc_valid_i = 1'b1;
    f.pc_wd_i = 32'hFFFF_FFFC;
    tick();
    f.pc_valid_i = 1'b0;
    chk("wrap_addr", f.imem_addr_o, 32'hFFFF_FFFC);
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'h0000_0077;
    tick();
    f.imem_ack_i = 1'b0;
    chk("wrap_ir", f.ir_o, 32'h0000_0077);
    chk("wrap_pc", f.pc_o, 32'hFFFF_FFFC);
    f.ir_ready_i = 1'b1;
    tick();
    f.ir_ready_i = 1'b0;

    // Misaligned PC load
    f.pc_valid_i = 1'b1;
    f.pc_wd_i = 32'h0000_0102;
    tick();
    f.pc_valid_i = 1'b0;
`ifdef FETCH_MISALIGN_EN
    chk("mis_req", 32'(f.imem_req_o), 32'd0);
    chk("mis_flag", 32'(f.misalign_o), 32'd1);
    chk("mis_pc", f.pc_o, 32'h0000_0102);
    f.imem_ack_i = 1'b1;
    tick();
    tick();
    f.imem_ack_i = 1'b0;
    chk("mis_stuck_req", 32'(f.imem_req_o), 32'd0);
    chk("mis_stuck_valid", 32'(f.ir_valid_o), 32'd0);
    chk("mis_stuck_flag", 32'(f.misalign_o), 32'd1);
`else
    chk("mis_req", 32'(f.imem_req_o), 32'd1);
    chk("mis_addr", f.imem_addr_o, 32'h0000_0100);
    chk("mis_flag", 32'(f.misalign_o), 32'd0);
    f.imem_ack_i = 1'b1;
    f.imem_data_i = 32'h0000_0033;
    tick();
    f.imem_ack_i = 1'b0;
    chk("mis_ir", f.ir_o, 32'h0000_0033);
    chk("mis_pc", f.pc_o, 32'h0000_0100);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port pc_wd_i  input  32  next PC from writeback.
REQ-005 SHALL have port pc_valid_i  input  1  pc_wd_i is valid this cycle, single-cycle pulse.
REQ-006 SHALL have port imem_req_o  output  1  instruction-memory read request.
REQ-007 SHALL have port imem_addr_o  output  32  read address.
REQ-008 SHALL have port imem_ack_i  input  1  imem_data_i is valid this cycle.
REQ-009 SHALL have port imem_data_i  input  32  instruction word.
REQ-010 SHALL have port ir_o  output  32  fetched instruction.
REQ-011 SHALL have port pc_o  output  32  address of ir_o.
REQ-012 SHALL have port ir_valid_o  output  1  ir_o/pc_o offered to decode.
REQ-013 SHALL have port ir_ready_i  input  1  decode accepts ir_o.
REQ-014 SHALL have port overrun_o  output  1  sticky flag: pc_valid_i arrived outside WAIT_PC.
REQ-015 SHALL have port misalign_o  output  1  sticky misaligned-PC fault flag.

Function
REQ-016 SHALL implement the states BOOT, REQ, HOLD, WAIT_PC and FAULT.
REQ-017 BOOT SHALL move to REQ on the first clock edge after reset release.
REQ-018 REQ SHALL drive imem_req_o=1 and imem_addr_o=pc.
- imem_addr_o SHALL remain stable while imem_req_o=1.
- On imem_ack_i, ir SHALL take imem_data_i and the state SHALL move to HOLD.
REQ-019 An imem_ack_i that arrives in the first REQ cycle SHALL be accepted, giving a minimum request-to-capture time of one cycle.
REQ-020 HOLD SHALL drive ir_valid_o=1.
- ir_o and pc_o SHALL stay stable in HOLD.
- When ir_ready_i=1, the state SHALL move to WAIT_PC.
- ir_ready_i SHALL be ignored in all other states.
REQ-021 In WAIT_PC, pc_valid_i=1 SHALL load pc from pc_wd_i and move the state to REQ.
- imem_req_o SHALL rise on the next cycle, giving a latency of 1.
REQ-022 pc_valid_i in BOOT, REQ, HOLD or FAULT SHALL be discarded and SHALL set overrun_o=1 until reset.
REQ-023 imem_ack_i outside REQ SHALL be ignored.
REQ-024 imem_req_o SHALL be 0 in every state except REQ.
REQ-025 ir_valid_o SHALL be 0 in every state except HOLD.
REQ-026 pc arithmetic SHALL be 32-bit and SHALL wrap modulo 2^32; pc_wd_i=32'hFFFF_FFFC SHALL be fetched as-is.
REQ-027 pc_o SHALL equal the address used for the fetch that produced ir_o.

Reset
REQ-028 Asserting reset SHALL immediately force the following values:
- state BOOT, pc=RESET_PC, ir_o=0;
- imem_req_o=0, ir_valid_o=0;
- overrun_o=0, misalign_o=0.
REQ-029 Reset asserted mid-request SHALL drop imem_req_o in the same cycle, without waiting for imem_ack_i.
REQ-030 An ack that belongs to the aborted request and arrives after reset release SHALL be ignored because it arrives in BOOT.

Configuration
REQ-031 Macro FETCH_MISALIGN_EN SHALL enable alignment checking.
REQ-032 With FETCH_MISALIGN_EN defined, the following SHALL apply:
- pc_valid_i in WAIT_PC with pc_wd_i[1:0]!=0 SHALL load pc, issue no request and enter FAULT.
- In FAULT, misalign_o=1, pc_o SHALL hold the faulting address, and the block SHALL leave FAULT only by reset.
REQ-033 Without FETCH_MISALIGN_EN, the following SHALL apply:
- pc_wd_i[1:0] SHALL be forced to 2'b00 on load.
- FAULT SHALL be unreachable and misalign_o SHALL be tied 0.

Verification
REQ-034 Reset release, RESET_PC=0, ack after 2 cycles with 32'h0000_0093 -> imem_addr_o=0; ir_valid_o=1 next cycle; ir_o=32'h0000_0093, pc_o=0.
REQ-035 WAIT_PC, pc_valid_i with pc_wd_i=32'h0000_0104, ack in the first REQ cycle -> imem_req_o=1 for exactly 1 cycle with addr 32'h0000_0104; ir_valid_o on the following cycle.
REQ-036 HOLD with ir_ready_i=0 for 5 cycles, then 1 -> ir_o stable for 6 cycles; state WAIT_PC after the accept.
REQ-037 pc_valid_i pulse during REQ -> pulse ignored, imem_addr_o unchanged, overrun_o=1 until reset.
REQ-038 reset asserted during REQ while awaiting ack -> imem_req_o=0 immediately; after release, fetch at RESET_PC; a stale ack arriving in BOOT is ignored.
REQ-039 With FETCH_MISALIGN_EN, pc_wd_i=32'h0000_0102 -> no request; misalign_o=1; pc_o=32'h0000_0102.
- Without the macro, the same stimulus SHALL fetch address 32'h0000_0100.
